fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 16-bit Harvard processor. Owns the program counter, reads 32-bit instruction words from the separate instruction memory over a request/acknowledge handshake, and holds each word stable on `code` until the decode stage consumes it. Branch redirects from later stages flush in-flight fetches.

## Interface
Parameters:
- `IMEM_AW`, default 8: instruction-memory address width, which is also the PC width.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `imem_req`, output, 1: fetch request; combinational from state.
- `imem_addr`, output, IMEM_AW: fetch address; equals `pc` while `imem_req` is 1.
- `imem_ack`, input, 1: instruction memory response valid.
- `imem_rdata`, input, 32: instruction word; valid when `imem_ack` is 1.
- `stall`, input, 1: decode stage not ready; holds the current instruction.
- `branch_valid`, input, 1: one-cycle redirect pulse.
- `branch_target`, input, IMEM_AW: new PC for a redirect.
- `code`, output, 32: instruction word driven to the decoder.
- `code_valid`, output, 1: `code` holds a live instruction.
- `code_pc`, output, IMEM_AW: address the current `code` word was fetched from.
- `halted`, output, 1: fetch stopped by a halt opcode (see Configuration).

## Operation
- States are FETCH, WAIT, HOLD and HALT. Reset enters FETCH.
- **FETCH**
  - `imem_req = !branch_valid`, `imem_addr = pc`.
  - No branch: next state is WAIT.
  - Branch: `pc <= branch_target`, stay in FETCH, no request issued.
- **WAIT**
  - `imem_req = 0`. Waits indefinitely for `imem_ack`.
  - On `imem_ack` with `flush = 0` and no `branch_valid`:
    - `code <= imem_rdata`, `code_pc <= pc`, `pc <= pc + 1`.
    - `code_valid <= 1`, next state HOLD.
  - On `imem_ack` with `flush = 1`: the response is discarded, `flush <= 0`, next state FETCH.
  - `branch_valid` without `imem_ack`: `pc <= branch_target`, `flush <= 1`, stay in WAIT.
  - `branch_valid` together with `imem_ack`: the response is discarded, `pc <= branch_target`, `flush <= 0`, next state FETCH.
- **HOLD**
  - `code_valid = 1`; `code` and `code_pc` are frozen.
  - The instruction is consumed in the cycle where `code_valid & !stall`.
  - On consume: `code_valid <= 0`, next state FETCH (or HALT, see Configuration).
  - `stall = 1`: stay in HOLD, all outputs unchanged.
  - `branch_valid` (takes priority over `stall`): `code_valid <= 0`, `pc <= branch_target`, next state FETCH.
- **HALT**
  - `imem_req = 0`, `code_valid = 0`, `halted = 1`.
  - Only `branch_valid` (`pc <= branch_target`, next state FETCH) or `rst` leaves HALT.
- PC arithmetic is modulo 2^IMEM_AW: `pc = 2^IMEM_AW - 1` increments to 0 with no flag.
- `imem_ack` is ignored in FETCH, HOLD and HALT.

## Timing
- Reset values: `pc = RESET_PC`, state FETCH, `flush = 0`, `code = 32'h0`, `code_pc = RESET_PC`, `code_valid = 0`, `halted = 0`.
- `imem_req` is high in the first cycle after reset deassertion.
- Memory contract: the request is sampled in the cycle `imem_req` is 1. The response arrives in any later cycle. At most one request is outstanding.
- Latency:
  - `code_valid` rises on the edge that samples `imem_ack`.
  - With ack in the cycle after the request, minimum spacing is 3 cycles per instruction (FETCH, WAIT, HOLD).
- Redirect: the first request to `branch_target` is issued 1 cycle after `branch_valid` from FETCH or HOLD. From WAIT it is issued 1 cycle after the pending ack.
- `rst` asserted mid-operation immediately clears state and outputs. An ack arriving after `rst` is ignored.

## Configuration
- `FETCH_HALT_EN` defined:
  - When an instruction with `code[31:26] == 6'b111111` is consumed in HOLD, next state is HALT and `halted <= 1`.
  - `pc` keeps the already-incremented value.
- `FETCH_HALT_EN` undefined:
  - Opcode `6'b111111` is fetched like any other word.
  - The HALT state is not built and `halted` is tied to 0.

## Test plan
- Reset then memory returning `32'h04221020` at address 0 with 1-cycle ack: `imem_addr=0` in cycle 1; `code=32'h04221020`, `code_pc=0`, `code_valid=1` in cycle 3; next request at address 1.
- Stall: hold `stall=1` for 5 cycles during HOLD. `code` and `code_pc` stay unchanged and no `imem_req` is issued. Request at `pc+1` appears 1 cycle after `stall` drops.
- Branch in WAIT: `branch_valid` with target `8'h40` while ack is delayed 4 cycles. The late data is discarded (`code_valid` stays 0). The next request is at address `0x40`.
- Branch with simultaneous ack: ack data is discarded and `imem_addr=0x40` in the next cycle. Branch during stalled HOLD: `code_valid` drops and the next fetch is from the target.
- Wrap: branch to `8'hFF`, consume it. The next `imem_addr` is `8'h00`.
- With `FETCH_HALT_EN`, fetch word `32'hFC000000`:
  - After it is consumed, `halted=1` and no further `imem_req` for 20 cycles.
  - `branch_valid` to `0x10` then resumes fetching at `0x10`.
  - With the macro undefined, the same word is followed by a fetch at the next address.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory handshake, the branch redirect and the
// decoder-facing instruction outputs of the fetch stage.
// The master modport is the fetch unit. The slave modport is the surrounding
// pipeline together with the instruction memory.
interface fetch_if #(
    parameter int IMEM_AW = 8
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               stall;
    logic               branch_valid;
    logic [IMEM_AW-1:0] branch_target;
    logic [31:0]        code;
    logic               code_valid;
    logic [IMEM_AW-1:0] code_pc;
    logic               halted;

    modport master (
        output imem_req, imem_addr, code, code_valid, code_pc, halted,
        input  imem_ack, imem_rdata, stall, branch_valid, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, code, code_valid, code_pc, halted,
        output imem_ack, imem_rdata, stall, branch_valid, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 16-bit Harvard processor.
// The stage owns the PC and fetches one 32-bit word at a time over a req/ack
// handshake. It holds the word on code until decode consumes it. A branch redirect
// flushes any fetch that is still in flight.
// Optional feature: define FETCH_HALT_EN to stop fetching after a consumed word
// with opcode 6'b111111. Without the macro, halted is tied to 0.
module fetch_unit #(
    parameter int                 IMEM_AW  = 8,
    parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [IMEM_AW-1:0] r_pc;
    logic [IMEM_AW-1:0] r_code_pc;
    logic [31:0]        r_code;
    logic               r_code_valid;
    logic               r_flush;

    logic [IMEM_AW-1:0] w_pc_inc;
    logic               w_halt_op;

    // PC increment wraps modulo 2^IMEM_AW and raises no flag.
    assign w_pc_inc = r_pc + IMEM_AW'(1);

`ifdef FETCH_HALT_EN
    logic r_halted;

    assign w_halt_op  = (r_code[31:26] == 6'b111111);
    assign bus.halted = r_halted;
`else
    assign w_halt_op  = 1'b0;
    assign bus.halted = 1'b0;
`endif

    // The request is decoded from the state. A redirect in FETCH suppresses it so
    // that no request goes out to the stale PC.
    assign bus.imem_req   = (r_state == S_FETCH) && !bus.branch_valid;
    assign bus.imem_addr  = r_pc;
    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.code_pc    = r_code_pc;

    // Fetch FSM: the PC, the flush marker and all registered decoder outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_flush      <= 1'b0;
            r_code       <= 32'h0;
            r_code_pc    <= RESET_PC;
            r_code_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted     <= 1'b0;
`endif
        end else begin
            // NOTE: every state register here uses non-blocking assignment. Each
            // branch then reads the pre-edge values of r_pc and r_code, and the
            // result does not depend on statement order.
            case (r_state)
                S_FETCH: begin
                    if (bus.branch_valid) begin
                        r_pc <= bus.branch_target;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.imem_ack) begin
                        if (bus.branch_valid) begin
                            // Redirect together with the response: drop the data and refetch at once.
                            r_pc    <= bus.branch_target;
                            r_flush <= 1'b0;
                            r_state <= S_FETCH;
                        end else if (r_flush) begin
                            // The response belongs to a path that was already redirected.
                            r_flush <= 1'b0;
                            r_state <= S_FETCH;
                        end else begin
                            r_code       <= bus.imem_rdata;
                            r_code_pc    <= r_pc;
                            r_pc         <= w_pc_inc;
                            r_code_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else if (bus.branch_valid) begin
                        // The memory still owes one response. Remember to discard it.
                        r_pc    <= bus.branch_target;
                        r_flush <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (bus.branch_valid) begin
                        r_code_valid <= 1'b0;
                        r_pc         <= bus.branch_target;
                        r_state      <= S_FETCH;
                    end else if (!bus.stall) begin
                        r_code_valid <= 1'b0;
`ifdef FETCH_HALT_EN
                        if (w_halt_op) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                        end
`else
                        r_state <= w_halt_op ? S_HALT : S_FETCH;
`endif
                    end
                end

`ifdef FETCH_HALT_EN
                S_HALT: begin
                    if (bus.branch_valid) begin
                        r_pc     <= bus.branch_target;
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
`endif

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The bench plays the instruction memory and the downstream pipeline.
// Its reference model tracks only the sequential PC. Each fetch is expected at the
// previous consumed address + 1 (mod 256) or at the most recent branch target.
// Each returned word must match the memory image.
module tb_fetch_unit;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_if #(.IMEM_AW(AW)) bus ();

    fetch_unit #(.IMEM_AW(AW), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];
    logic [7:0]  model_pc;

    // Advance to the next cycle's midpoint and return all inputs to idle.
    task automatic next_cycle();
        @(negedge clk);
        bus.imem_ack      = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_target = 8'($urandom);
        bus.imem_rdata    = $urandom;
    endtask

    // Wait (bounded) for a request and compare its address. n is the number of cycles waited.
    task automatic wait_req(input logic [7:0] exp_addr, input string name, output int n);
        n = 0;
        do begin
            next_cycle();
            #1;
            n++;
        end while (bus.imem_req !== 1'b1 && n < 20);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s: req=%b addr=%h, required req=1 addr=%h",
                     name, bus.imem_req, bus.imem_addr, exp_addr);
        end
    endtask

    // Answer the pending request after lat cycles, then hold the word for stalls cycles before consuming it.
    task automatic finish_fetch(input logic [7:0] addr, input int lat, input int stalls, input string name);
        logic [31:0] data;
        data = mem[addr];
        for (int i = 1; i <= lat; i++) begin
            next_cycle();
            if (i == lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = data;
            end
            #1;
            checks++;
            if (bus.imem_req !== 1'b0 || bus.code_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s wait: req=%b valid=%b, required 0 0",
                         name, bus.imem_req, bus.code_valid);
            end
        end
        for (int s = 0; s <= stalls; s++) begin
            next_cycle();
            bus.stall = (s < stalls);
            #1;
            checks++;
            if (bus.code_valid !== 1'b1 || bus.code !== data || bus.code_pc !== addr || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: valid=%b code=%h pc=%h req=%b, required 1 %h %h 0",
                         name, bus.code_valid, bus.code, bus.code_pc, bus.imem_req, data, addr);
            end
        end
        model_pc = addr + 8'd1;
    endtask

    task automatic check_n(input int n, input int exp_n, input string name);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s latency: %0d cycles, required %0d", name, n, exp_n);
        end
    endtask

    task automatic check_valid_low(input string name);
        checks++;
        if (bus.code_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: code_valid=%b, required 0", name, bus.code_valid);
        end
    endtask

    task automatic test_reset();
        int n;
        rst                = 1'b1;
        bus.imem_ack       = 1'b0;
        bus.branch_valid   = 1'b0;
        bus.stall          = 1'b0;
        bus.branch_target  = 8'h00;
        bus.imem_rdata     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.code !== 32'h0 || bus.code_pc !== 8'h00 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b code=%h pc=%h halted=%b, required 0 00000000 00 0",
                     bus.code_valid, bus.code, bus.code_pc, bus.halted);
        end
        rst      = 1'b0;
        model_pc = 8'h00;
        wait_req(8'h00, "reset_first_req", n);
        check_n(n, 1, "reset_first_req");
    endtask

    // Ends in the request cycle left behind by test_reset.
    task automatic test_basic();
        int n;
        finish_fetch(8'h00, 1, 0, "basic0");
        wait_req(8'h01, "basic_next_req", n);
        check_n(n, 1, "basic_spacing");
        finish_fetch(8'h01, 2, 0, "basic1");
    endtask

    task automatic test_stall();
        int n;
        logic [7:0] a;
        a = model_pc;
        wait_req(a, "stall_req", n);
        finish_fetch(a, 1, 5, "stall_hold");
        wait_req(a + 8'd1, "stall_next_req", n);
        check_n(n, 1, "stall_next_req");
        finish_fetch(a + 8'd1, 1, 0, "stall_after");
    endtask

    task automatic test_branch_wait();
        int n;
        logic [7:0] a;
        a = model_pc;
        wait_req(a, "bwait_req", n);
        next_cycle();
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'h40;
        #1;
        check_valid_low("bwait_branch");
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            if (i == 3) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem[a];
            end
            #1;
            checks++;
            if (bus.code_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL bwait_pending: valid=%b req=%b, required 0 0", bus.code_valid, bus.imem_req);
            end
        end
        wait_req(8'h40, "bwait_target_req", n);
        check_n(n, 1, "bwait_target_req");
        check_valid_low("bwait_discard");
        finish_fetch(8'h40, 2, 0, "bwait_target");
    endtask

    task automatic test_branch_ack();
        int n;
        logic [7:0] a;
        a = model_pc;
        wait_req(a, "back_req", n);
        next_cycle();
        bus.imem_ack      = 1'b1;
        bus.imem_rdata    = mem[a];
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'h40;
        #1;
        wait_req(8'h40, "back_target_req", n);
        check_n(n, 1, "back_target_req");
        check_valid_low("back_discard");
        finish_fetch(8'h40, 1, 0, "back_target");
    endtask

    task automatic test_branch_hold();
        int n;
        logic [7:0] a;
        logic [7:0] t;
        a = model_pc;
        t = 8'($urandom);
        wait_req(a, "bhold_req", n);
        next_cycle();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem[a];
        next_cycle();
        bus.stall = 1'b1;
        #1;
        checks++;
        if (bus.code_valid !== 1'b1 || bus.code !== mem[a]) begin
            errors++;
            $display("FAIL bhold_hold: valid=%b code=%h, required 1 %h", bus.code_valid, bus.code, mem[a]);
        end
        next_cycle();
        bus.stall         = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = t;
        #1;
        wait_req(t, "bhold_target_req", n);
        check_n(n, 1, "bhold_target_req");
        check_valid_low("bhold_drop");
        finish_fetch(t, 1, 0, "bhold_target");
    endtask

    task automatic test_wrap();
        int n;
        next_cycle();
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'hFF;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_branch_req: req=%b, required 0", bus.imem_req);
        end
        wait_req(8'hFF, "wrap_ff_req", n);
        check_n(n, 1, "wrap_ff_req");
        finish_fetch(8'hFF, 1, 0, "wrap_ff");
        wait_req(8'h00, "wrap_00_req", n);
        check_n(n, 1, "wrap_00_req");
        finish_fetch(8'h00, 1, 0, "wrap_00");
    endtask

    task automatic test_halt();
        int n;
        logic [7:0]  a;
        logic [31:0] saved;
        a      = model_pc;
        saved  = mem[a];
        mem[a] = 32'hFC000000;
        wait_req(a, "halt_req", n);
        finish_fetch(a, 1, 0, "halt_word");
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            bus.imem_ack = (i % 3 == 0);
            #1;
            checks++;
            if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.code_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_idle: req=%b halted=%b valid=%b, required 0 1 0",
                         bus.imem_req, bus.halted, bus.code_valid);
            end
        end
        next_cycle();
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'h10;
        #1;
        wait_req(8'h10, "halt_resume_req", n);
        check_n(n, 1, "halt_resume_req");
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear: halted=%b, required 0", bus.halted);
        end
        finish_fetch(8'h10, 1, 0, "halt_resume");
`else
        wait_req(a + 8'd1, "nohalt_next_req", n);
        check_n(n, 1, "nohalt_next_req");
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL nohalt_flag: halted=%b, required 0", bus.halted);
        end
        finish_fetch(a + 8'd1, 1, 0, "nohalt_next");
`endif
        mem[a] = saved;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] a;
        a = model_pc;
        wait_req(a, "rmid_req", n);
        next_cycle();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem[a];
        next_cycle();
        bus.stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.code !== 32'h0 || bus.code_pc !== 8'h00) begin
            errors++;
            $display("FAIL rmid_clear: valid=%b code=%h pc=%h, required 0 00000000 00",
                     bus.code_valid, bus.code, bus.code_pc);
        end
        next_cycle();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_req(8'h00, "rmid_restart_req", n);
        check_n(n, 1, "rmid_restart_req");
        check_valid_low("rmid_ack_ignored");
        finish_fetch(8'h00, 1, 0, "rmid_restart");
    endtask

    task automatic test_random();
        int n;
        int kind;
        int extra;
        logic [7:0] a;
        logic [7:0] t;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            t    = 8'($urandom);
            a    = model_pc;
            case (kind)
                0: begin
                    wait_req(a, "rnd_seq_req", n);
                    finish_fetch(a, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), "rnd_seq");
                end
                1: begin
                    next_cycle();
                    bus.branch_valid  = 1'b1;
                    bus.branch_target = t;
                    #1;
                    wait_req(t, "rnd_bfetch_req", n);
                    check_n(n, 1, "rnd_bfetch_req");
                    finish_fetch(t, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), "rnd_bfetch");
                end
                2: begin
                    wait_req(a, "rnd_bwait_req", n);
                    extra = int'($urandom_range(0, 3));
                    next_cycle();
                    bus.branch_valid  = 1'b1;
                    bus.branch_target = t;
                    bus.imem_ack      = (extra == 0);
                    for (int i = 1; i <= extra; i++) begin
                        next_cycle();
                        bus.imem_ack = (i == extra);
                        #1;
                        check_valid_low("rnd_bwait_pending");
                    end
                    wait_req(t, "rnd_bwait_target_req", n);
                    check_n(n, 1, "rnd_bwait_target_req");
                    check_valid_low("rnd_bwait_discard");
                    finish_fetch(t, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), "rnd_bwait");
                end
                default: begin
                    wait_req(a, "rnd_bhold_req", n);
                    next_cycle();
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem[a];
                    next_cycle();
                    bus.stall         = $urandom_range(0, 1) == 1;
                    bus.branch_valid  = 1'b1;
                    bus.branch_target = t;
                    wait_req(t, "rnd_bhold_target_req", n);
                    check_n(n, 1, "rnd_bhold_target_req");
                    check_valid_low("rnd_bhold_drop");
                    finish_fetch(t, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), "rnd_bhold");
                end
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'b111111) mem[i][26] = 1'b0;
        end
        mem[0] = 32'h04221020;

        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_branch_ack();
        test_branch_hold();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
